// File: rtl/avalon_mm_master.sv
// Single-outstanding Avalon-MM master: one valid/ready command -> one Avalon transfer.
// Optional waitrequest timeout: define AVALON_MM_MASTER_TIMEOUT_EN.
module avalon_mm_master #(
    parameter int AW     = 8,
    parameter int RD_LAT = 0,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] address,
    output logic [31:0]   writedata,
    input  logic [31:0]   readdata,
    output logic          write,
    output logic          read,
    output logic          chipselect,
    input  logic          waitrequest
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RDWAIT,
        RESP
    } state_t;

    localparam logic [1:0]  LAT    = 2'(RD_LAT);
    localparam logic [15:0] TO_LIM = 16'(TO_CYC);

    state_t        state, state_n;
    logic          we_q, we_n;
    logic [1:0]    lat_cnt, lat_n;
    logic [AW-1:0] addr_n;
    logic [31:0]   wdata_n;
    logic [31:0]   rdata_n;
    logic          cs_n, rd_n, wr_n;
    logic          rv_n, err_n;

`ifdef AVALON_MM_MASTER_TIMEOUT_EN
    logic [15:0] to_cnt, to_n, to_inc;

    assign to_inc = to_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_n;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^TO_LIM;
`endif

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            lat_cnt    <= '0;
            address    <= '0;
            writedata  <= '0;
            chipselect <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_n;
            we_q       <= we_n;
            lat_cnt    <= lat_n;
            address    <= addr_n;
            writedata  <= wdata_n;
            chipselect <= cs_n;
            read       <= rd_n;
            write      <= wr_n;
            rsp_valid  <= rv_n;
            rsp_rdata  <= rdata_n;
            rsp_err    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        we_n    = we_q;
        lat_n   = lat_cnt;
        addr_n  = address;
        wdata_n = writedata;
        cs_n    = chipselect;
        rd_n    = read;
        wr_n    = write;
        rv_n    = 1'b0;
        rdata_n = rsp_rdata;
        err_n   = 1'b0;
`ifdef AVALON_MM_MASTER_TIMEOUT_EN
        to_n    = to_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_n = REQ;
                    we_n    = cmd_we;
                    addr_n  = cmd_addr;
                    wdata_n = cmd_wdata;
                    cs_n    = 1'b1;
                    wr_n    = cmd_we;
                    rd_n    = ~cmd_we;
`ifdef AVALON_MM_MASTER_TIMEOUT_EN
                    to_n    = '0;
`endif
                end
            end
            REQ: begin
                if (!waitrequest) begin
                    cs_n = 1'b0;
                    rd_n = 1'b0;
                    wr_n = 1'b0;
                    if (we_q) begin
                        rdata_n = '0;
                        rv_n    = 1'b1;
                        state_n = RESP;
                    end else if (RD_LAT == 0) begin
                        rdata_n = readdata;
                        rv_n    = 1'b1;
                        state_n = RESP;
                    end else begin
                        lat_n   = 2'd1;
                        state_n = RDWAIT;
                    end
                end
`ifdef AVALON_MM_MASTER_TIMEOUT_EN
                // A stall that lands the counter on the limit abandons the request.
                else if (to_inc == TO_LIM) begin
                    cs_n    = 1'b0;
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    rdata_n = '0;
                    err_n   = 1'b1;
                    rv_n    = 1'b1;
                    to_n    = to_inc;
                    state_n = RESP;
                end else begin
                    to_n = to_inc;
                end
`endif
            end
            RDWAIT: begin
                if (lat_cnt == LAT) begin
                    rdata_n = readdata;
                    rv_n    = 1'b1;
                    state_n = RESP;
                end else begin
                    lat_n = lat_cnt + 2'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_avalon_mm_master.sv
// Randomised bench for avalon_mm_master: two instances (RD_LAT 0 and 2)
// checked against a per-transaction timeline model.
module tb_avalon_mm_master;

    localparam int TO = 4;
`ifdef AVALON_MM_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cv0 = 1'b0, cv2 = 1'b0;
    logic        cmd_we = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] readdata = '0;
    logic        waitrequest = 1'b0;
    bit          sel = 1'b0;

    logic        rdy0, rv0, err0, wr0, rd0, cs0;
    logic [31:0] rdat0, wd0;
    logic [7:0]  a0;
    logic        rdy2, rv2, err2, wr2, rd2, cs2;
    logic [31:0] rdat2, wd2;
    logic [7:0]  a2;

    logic        o_rdy, o_rv, o_err, o_wr, o_rd, o_cs;
    logic [31:0] o_rdat, o_wd;
    logic [7:0]  o_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_mm_master #(.AW(8), .RD_LAT(0), .TO_CYC(TO)) u_d0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cv0), .cmd_ready(rdy0), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv0), .rsp_rdata(rdat0), .rsp_err(err0),
        .address(a0), .writedata(wd0), .readdata(readdata),
        .write(wr0), .read(rd0), .chipselect(cs0),
        .waitrequest(waitrequest)
    );

    avalon_mm_master #(.AW(8), .RD_LAT(2), .TO_CYC(TO)) u_d2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cv2), .cmd_ready(rdy2), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv2), .rsp_rdata(rdat2), .rsp_err(err2),
        .address(a2), .writedata(wd2), .readdata(readdata),
        .write(wr2), .read(rd2), .chipselect(cs2),
        .waitrequest(waitrequest)
    );

    always_comb begin
        o_rdy  = sel ? rdy2  : rdy0;
        o_rv   = sel ? rv2   : rv0;
        o_err  = sel ? err2  : err0;
        o_wr   = sel ? wr2   : wr0;
        o_rd   = sel ? rd2   : rd0;
        o_cs   = sel ? cs2   : cs0;
        o_rdat = sel ? rdat2 : rdat0;
        o_wd   = sel ? wd2   : wd0;
        o_a    = sel ? a2    : a0;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)",
                     tag, obs, exp, $time, sel);
        end
    endtask

    // Timeline model: cycle k counts from the cycle after the accept edge.
    // Strobes occupy k=1..ka, readdata is wanted at k=ka+lat, response at kr.
    task automatic run_txn(input bit s, input bit we, input logic [7:0] a,
                           input logic [31:0] wd, input int stalls,
                           input logic [31:0] rdv);
        int lat, ka, kr;
        bit to_hit;
        logic [31:0] exp_rd;
        lat    = (we || !s) ? 0 : 2;
        to_hit = TO_EN && (stalls >= TO);
        if (to_hit) begin
            ka  = TO;
            lat = 0;
        end else begin
            ka = stalls + 1;
        end
        kr     = ka + lat + 1;
        exp_rd = (we || to_hit) ? 32'h0 : rdv;
        sel       = s;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = wd;
        if (s) cv2 = 1'b1;
        else   cv0 = 1'b1;
        check("ready_before", o_rdy, 1);
        @(posedge clk); #1;
        cv0 = 1'b0;
        cv2 = 1'b0;
        for (int k = 1; k <= kr + 1; k++) begin
            bit on;
            on = (k <= ka);
            check("chipselect", o_cs, on);
            check("write", o_wr, on && we);
            check("read", o_rd, on && !we);
            check("cmd_ready", o_rdy, k > kr);
            check("rsp_valid", o_rv, k == kr);
            if (on) begin
                check("address", o_a, a);
                if (we) check("writedata", o_wd, wd);
            end
            if (k == kr) begin
                check("rsp_rdata", o_rdat, exp_rd);
                check("rsp_err", o_err, to_hit);
            end
            if (k == kr + 1) break;
            if (k <= stalls) waitrequest = 1'b1;
            else if (k > ka) waitrequest = 1'($urandom_range(0, 1));
            else waitrequest = 1'b0;
            readdata = (!we && k == ka + lat) ? rdv : $urandom;
            // Busy-time command noise must be ignored.
            if (k < kr) begin
                cmd_we    = 1'($urandom_range(0, 1));
                cmd_addr  = 8'($urandom);
                cmd_wdata = $urandom;
                if (s) cv2 = 1'($urandom_range(0, 1));
                else   cv0 = 1'($urandom_range(0, 1));
            end else begin
                cv0 = 1'b0;
                cv2 = 1'b0;
            end
            @(posedge clk); #1;
        end
        waitrequest = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs", cs0 | cs2, 0);
        check("rst_strobes", {rd0, wr0, rd2, wr2}, 0);
        check("rst_rsp", {rv0, err0, rv2, err2}, 0);
        check("rst_addr", {a0, a2}, 0);
        check("rst_wdata", wd0 | wd2, 0);
        check("rst_rdata", rdat0 | rdat2, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", {rdy0, rdy2}, 2'b11);

        run_txn(1'b0, 1'b1, 8'h00, 32'h1, 0, 32'h0);
        run_txn(1'b0, 1'b1, 8'h3c, 32'hdead_beef, 2, 32'h0);
        run_txn(1'b0, 1'b0, 8'h04, 32'h0, 0, 32'h0000_0001);
        run_txn(1'b1, 1'b0, 8'h08, 32'h0, 0, 32'ha5a5_5a5a);
        run_txn(1'b0, 1'b0, 8'h10, 32'h0, TO + 2, 32'h1234_5678);
        run_txn(1'b0, 1'b1, 8'h11, 32'h55, 0, 32'h0);
        run_txn(1'b1, 1'b1, 8'h12, 32'h66, TO - 1, 32'h0);
        run_txn(1'b1, 1'b0, 8'h13, 32'h0, TO, 32'hcafe_f00d);

        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), $urandom, $urandom_range(0, 6), $urandom);
        end

        sel       = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 8'h77;
        cv2       = 1'b1;
        @(posedge clk); #1;
        cv2         = 1'b0;
        waitrequest = 1'b1;
        check("mid_req_cs", o_cs, 1);
        @(posedge clk); #1;
        check("mid_req_rd", o_rd, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_cs", o_cs, 0);
        check("abort_strobes", {o_rd, o_wr}, 0);
        check("abort_rsp", o_rv, 0);
        rst         = 1'b0;
        waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("post_abort_ready", o_rdy, 1);
            check("post_abort_rsp", o_rv, 0);
            check("post_abort_cs", o_cs, 0);
            @(posedge clk); #1;
        end
        run_txn(1'b1, 1'b0, 8'h78, 32'h0, 1, 32'h0bad_c0de);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
